proc_run_ctrl: RTL and testbench
================================

Name: proc_run_ctrl

Overview:
Synthesizable run controller that drives the single-cycle core's program-run interface: resetl, startpc, currentpc and dmemout.
- Per request, it holds the core in reset with a chosen start PC, then releases it.
- It watches currentpc until a programmed end address, waits one settle cycle, then captures dmemout and compares it to an expected pass code.
- It keeps pass/run counters and a watchdog.
- It sits between a host/bench sequencer and the core, so on-chip self-test runs need no simulation-only bench.

Parameters:
PC_W, 64, width of PC ports
DATA_W, 64, width of data/pass-code ports
WDOG_W, 16, watchdog counter width
WDOG_LIMIT, 16'h00FF, RUN cycles before timeout
RESET_CYCLES, 1, cycles proc_resetl held low per run (must be >=1)

Ports:
CLK  in  1  system clock, rising edge
resetl  in  1  asynchronous active-low reset
start  in  1  run request, sampled in IDLE only
clr_counts  in  1  synchronous clear of pass_count/run_count
prog_startpc  in  PC_W  start PC for this run, latched on start
prog_endpc  in  PC_W  end PC, latched on start
expected  in  DATA_W  expected pass code, latched on start
proc_resetl  out  1  reset to core
proc_startpc  out  PC_W  start PC to core
proc_currentpc  in  PC_W  core's current PC
proc_dmemout  in  DATA_W  core's data-memory output
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
pass  out  1  last run result; valid from the done pulse until the next start
timeout  out  1  last run hit the watchdog; valid from the done pulse until the next start
result_data  out  DATA_W  captured dmemout of the last run
pass_count  out  8  saturating count of passed runs
run_count  out  8  saturating count of completed runs

Behaviour:
- Reset values (all registers asynchronous):
  - state=IDLE.
  - proc_resetl=0; it goes to 1 on the first edge after reset deasserts.
  - proc_startpc=0, busy=0, done=0, pass=0, timeout=0, result_data=0, counts=0, watchdog=0.
- States:
  - IDLE: proc_resetl=1.
    - start=1 → latch prog_startpc into proc_startpc, latch endpc and expected.
    - Clear pass, timeout and watchdog; load reset counter = RESET_CYCLES; go to HOLD.
  - HOLD: proc_resetl=0. Decrement the reset counter each edge; at 0 → RUN with proc_resetl=1.
  - RUN: each edge, increment the watchdog.
    - proc_currentpc >= endpc (unsigned) → SETTLE.
    - Otherwise, watchdog reaching WDOG_LIMIT → DONE with timeout=1 and pass=0.
    - The end-PC condition has priority over the watchdog on the same edge.
  - SETTLE: exactly one edge, which allows the final load to reach dmemout.
    - Capture proc_dmemout into result_data; pass = (proc_dmemout == expected).
    - Go to DONE.
  - DONE: done=1 for one cycle.
    - run_count += 1; pass_count += pass. Both saturate at 255.
    - Return to IDLE.
- start is ignored while busy; no queuing.
- clr_counts has priority over the DONE increment on the same edge.
- If prog_startpc >= prog_endpc, RUN exits on its first edge.
- Asynchronous reset mid-run: abort immediately, proc_resetl=0, no done pulse, counters cleared.
- Input changes after start have no effect, because all run inputs are latched.

Decomposition:
- Package proc_run_pkg contains:
  - state enum {IDLE, HOLD, RUN, SETTLE, DONE}
  - PC_W/DATA_W defaults
  - saturating-increment function
- One sub-module, run_watchdog: clear/enable/limit counter with an expired flag.

Test Plan:
- Bench core model: pc<=startpc while reset is low, otherwise pc+=4; dmemout=0xF. Run startpc=0, endpc=0x34, expected=0xF, start at edge E0.
  - proc_resetl low for 1 cycle.
  - done pulses at E0+17.
  - pass=1, timeout=0, result_data=0xF, pass_count=1, run_count=1.
- Same run with expected=0xE → pass=0, result_data=0xF, pass_count=0, run_count=1.
- Core model with PC stuck at 0, WDOG_LIMIT=0xFF → done with timeout=1 and pass=0 after 255 RUN cycles.
- startpc=0x40, endpc=0x34 → RUN exits on its first edge; done at E0+4.
- Assert resetl mid-RUN → busy=0 and proc_resetl=0 immediately; no done; counts=0.
- start pulsed while busy is ignored. Run 256 passes → pass_count saturates at 255. clr_counts coinciding with DONE → counts read 0.

Source files
------------

// File: rtl/proc_run_pkg.sv
// Shared types and helpers for the processor run controller.
package proc_run_pkg;

  localparam int unsigned PC_W_DEF   = 64;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } run_state_e;

  // Counts stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// Run-length watchdog: clearable, enable-gated counter that flags when the
// current enabled edge brings the count up to the limit.
module run_watchdog #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   count_next_s;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (en_i) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // One bit wider so the compare cannot be fooled by wrap-around.
  assign count_next_s = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
  assign expired_o    = en_i && (count_next_s >= {1'b0, limit_i});

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for the single-cycle core: holds it in reset at a chosen
// start PC, watches for the end PC, then grades the captured dmemout.
module proc_run_ctrl
  import proc_run_pkg::*;
#(
  parameter int unsigned          PC_W         = PC_W_DEF,
  parameter int unsigned          DATA_W       = DATA_W_DEF,
  parameter int unsigned          WDOG_W       = 16,
  parameter logic [WDOG_W-1:0]    WDOG_LIMIT   = WDOG_W'(16'h00FF),
  parameter int unsigned          RESET_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              start,
  input  logic              clr_counts,
  input  logic [PC_W-1:0]   prog_startpc,
  input  logic [PC_W-1:0]   prog_endpc,
  input  logic [DATA_W-1:0] expected,
  output logic              proc_resetl,
  output logic [PC_W-1:0]   proc_startpc,
  input  logic [PC_W-1:0]   proc_currentpc,
  input  logic [DATA_W-1:0] proc_dmemout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] result_data,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  run_count
);

  localparam int unsigned RST_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

  run_state_e        state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [PC_W-1:0]   startpc_q, startpc_d, endpc_q, endpc_d;
  logic [DATA_W-1:0] exp_q, exp_d, result_q, result_d;
  logic              pass_q, pass_d, timeout_q, timeout_d;
  logic              done_q, done_d, busy_q, busy_d, presetl_q, presetl_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, run_cnt_q, run_cnt_d;
  logic              wd_clr_s, wd_en_s, wd_expired_s;

  run_watchdog #(.W(WDOG_W)) u_wdog (
    .clk_i     (CLK),
    .rst_ni    (resetl),
    .clr_i     (wd_clr_s),
    .en_i      (wd_en_s),
    .limit_i   (WDOG_LIMIT),
    .expired_o (wd_expired_s)
  );

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    startpc_d  = startpc_q;
    endpc_d    = endpc_q;
    exp_d      = exp_q;
    result_d   = result_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    pass_cnt_d = pass_cnt_q;
    run_cnt_d  = run_cnt_q;
    wd_clr_s   = 1'b0;
    wd_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          startpc_d = prog_startpc;
          endpc_d   = prog_endpc;
          exp_d     = expected;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          wd_clr_s  = 1'b1;
          rst_cnt_d = RST_W'(RESET_CYCLES);
          state_d   = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        rst_cnt_d = rst_cnt_q - {{(RST_W-1){1'b0}}, 1'b1};
        if (rst_cnt_q <= {{(RST_W-1){1'b0}}, 1'b1}) begin
          state_d = RUN;
        end else begin
          state_d = HOLD;
        end
      end
      RUN: begin
        wd_en_s = 1'b1;
        // Reaching the end PC wins over a same-edge watchdog expiry.
        if (proc_currentpc >= endpc_q) begin
          state_d = SETTLE;
        end else if (wd_expired_s) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = DONE;
        end else begin
          state_d = RUN;
        end
      end
      SETTLE: begin
        result_d = proc_dmemout;
        pass_d   = (proc_dmemout == exp_q);
        state_d  = DONE;
      end
      DONE: begin
        run_cnt_d  = sat_inc(run_cnt_q, 1'b1);
        pass_cnt_d = sat_inc(pass_cnt_q, pass_q);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clr_counts) begin
      pass_cnt_d = {CNT_W{1'b0}};
      run_cnt_d  = {CNT_W{1'b0}};
    end else begin
      pass_cnt_d = pass_cnt_d;
    end
    presetl_d = (state_d != HOLD);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == DONE);
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q    <= IDLE;
      rst_cnt_q  <= {RST_W{1'b0}};
      startpc_q  <= {PC_W{1'b0}};
      endpc_q    <= {PC_W{1'b0}};
      exp_q      <= {DATA_W{1'b0}};
      result_q   <= {DATA_W{1'b0}};
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      presetl_q  <= 1'b0;
      pass_cnt_q <= {CNT_W{1'b0}};
      run_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      startpc_q  <= startpc_d;
      endpc_q    <= endpc_d;
      exp_q      <= exp_d;
      result_q   <= result_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      presetl_q  <= presetl_d;
      pass_cnt_q <= pass_cnt_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  assign proc_resetl  = presetl_q;
  assign proc_startpc = startpc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign result_data  = result_q;
  assign pass_count   = pass_cnt_q;
  assign run_count    = run_cnt_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: a simple core model plus a
// run-outcome model derived from PC arithmetic and the watchdog limit.
module tb_proc_run_ctrl;

  localparam int LIMIT = 255;
  localparam int RCYC  = 1;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic        start = 1'b0;
  logic        clr_counts = 1'b0;
  logic [63:0] prog_startpc = 64'd0;
  logic [63:0] prog_endpc = 64'd0;
  logic [63:0] expected = 64'd0;
  logic        proc_resetl;
  logic [63:0] proc_startpc;
  logic [63:0] proc_currentpc;
  logic [63:0] proc_dmemout;
  logic        busy, done, pass, timeout;
  logic [63:0] result_data;
  logic [7:0]  pass_count, run_count;

  int tests = 0;
  int fails = 0;

  logic [63:0] core_pc = 64'd0;
  logic [63:0] dmem_val = 64'd0;
  bit          stuck = 1'b0;

  int          m_pass_cnt = 0;
  int          m_run_cnt = 0;
  bit          m_pass = 1'b0;
  bit          m_to = 1'b0;
  logic [63:0] m_result = 64'd0;

  proc_run_ctrl dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .start          (start),
    .clr_counts     (clr_counts),
    .prog_startpc   (prog_startpc),
    .prog_endpc     (prog_endpc),
    .expected       (expected),
    .proc_resetl    (proc_resetl),
    .proc_startpc   (proc_startpc),
    .proc_currentpc (proc_currentpc),
    .proc_dmemout   (proc_dmemout),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .result_data    (result_data),
    .pass_count     (pass_count),
    .run_count      (run_count)
  );

  always #5 CLK = ~CLK;

  // Core model: loads start PC while held in reset, then steps by 4.
  always @(posedge CLK) begin
    if (stuck) core_pc <= 64'd0;
    else if (!proc_resetl) core_pc <= proc_startpc;
    else core_pc <= core_pc + 64'd4;
  end
  assign proc_currentpc = core_pc;
  assign proc_dmemout   = dmem_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat255(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic run_one(input logic [63:0] spc, input logic [63:0] epc,
                         input logic [63:0] expv, input logic [63:0] dval,
                         input bit stk, input bit clr_at_done, input bit noise);
    int n, k_exp, k_noise, lowcnt;
    bit to, got;
    // n = RUN edge on which the core's PC first reaches the end PC.
    if (stk) n = (epc == 64'd0) ? 1 : LIMIT + 1;
    else if (spc >= epc) n = 1;
    else n = int'((epc - spc + 64'd3) / 64'd4) + 1;
    to    = (n > LIMIT);
    k_exp = to ? (RCYC + LIMIT + 1) : (RCYC + n + 2);
    k_noise = noise ? int'($urandom_range(1, k_exp - 2)) : -1;

    @(negedge CLK);
    stuck = stk; dmem_val = dval;
    prog_startpc = spc; prog_endpc = epc; expected = expv; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    prog_startpc = {$urandom, $urandom}; prog_endpc = {$urandom, $urandom};
    expected = {$urandom, $urandom};
    check("hold_busy", {63'd0, busy}, 64'd1);
    check("startpc_latched", proc_startpc, spc);
    lowcnt = proc_resetl ? 0 : 1;
    got = 1'b0;
    for (int k = 1; k <= k_exp + 5 && !got; k++) begin
      @(posedge CLK); #1;
      if (!proc_resetl) lowcnt++;
      start = (k == k_noise);
      clr_counts = clr_at_done && (k == k_exp - 1);
      if (start) begin
        prog_startpc = 64'd0; prog_endpc = 64'd4; expected = ~expv;
      end
      if (done) begin
        got = 1'b1;
        check("done_latency", 64'(k), 64'(k_exp));
      end
    end
    start = 1'b0; clr_counts = 1'b0;
    check("done_seen", {63'd0, got}, 64'd1);

    m_run_cnt = sat255(m_run_cnt);
    m_pass = !to && (dval == expv);
    m_to = to;
    if (m_pass) m_pass_cnt = sat255(m_pass_cnt);
    if (!to) m_result = dval;
    if (clr_at_done) begin m_run_cnt = 0; m_pass_cnt = 0; end

    check("reset_low_cycles", 64'(lowcnt), 64'(RCYC));
    check("pass", {63'd0, pass}, {63'd0, m_pass});
    check("timeout", {63'd0, timeout}, {63'd0, m_to});
    check("result_data", result_data, m_result);
    check("pass_count", {56'd0, pass_count}, 64'(m_pass_cnt));
    check("run_count", {56'd0, run_count}, 64'(m_run_cnt));
    check("idle_at_done", {63'd0, busy}, 64'd0);
    @(posedge CLK); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int dcount;
    logic [63:0] d;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_proc_resetl", {63'd0, proc_resetl}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_pass_timeout", {62'd0, pass, timeout}, 64'd0);
    check("rst_result", result_data, 64'd0);
    check("rst_counts", {48'd0, pass_count, run_count}, 64'd0);
    check("rst_startpc", proc_startpc, 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    @(posedge CLK); #1;
    check("release_proc_resetl", {63'd0, proc_resetl}, 64'd1);

    run_one(64'd0, 64'h34, 64'hF, 64'hF, 1'b0, 1'b0, 1'b0);
    run_one(64'd0, 64'h34, 64'hE, 64'hF, 1'b0, 1'b0, 1'b0);
    run_one(64'd0, 64'h34, 64'hF, 64'hF, 1'b1, 1'b0, 1'b0);
    run_one(64'h40, 64'h34, 64'hF, 64'hF, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom};
      run_one(64'(4 * $urandom_range(0, 40)), 64'($urandom_range(0, 256)),
              ($urandom_range(0, 1) == 0) ? d : {$urandom, $urandom}, d,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1'b1);
    end

    @(negedge CLK);
    clr_counts = 1'b1;
    @(negedge CLK);
    clr_counts = 1'b0;
    m_run_cnt = 0; m_pass_cnt = 0;
    check("clr_idle", {48'd0, pass_count, run_count}, 64'd0);

    for (int i = 0; i < 256; i++) begin
      run_one(64'd0, 64'd0, 64'h1, 64'h1, 1'b0, 1'b0, (i % 16) == 0);
    end
    check("pass_count_sat", {56'd0, pass_count}, 64'd255);

    run_one(64'd8, 64'h20, 64'h5, 64'h5, 1'b0, 1'b1, 1'b0);
    run_one(64'd0, 64'h10, 64'h7, 64'h7, 1'b0, 1'b0, 1'b0);

    @(negedge CLK);
    stuck = 1'b1; prog_startpc = 64'd0; prog_endpc = 64'h34; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    check("busy_before_abort", {63'd0, busy}, 64'd1);
    resetl = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_proc_resetl", {63'd0, proc_resetl}, 64'd0);
    check("abort_counts", {48'd0, pass_count, run_count}, 64'd0);
    m_run_cnt = 0; m_pass_cnt = 0; m_pass = 1'b0; m_to = 1'b0; m_result = 64'd0;
    repeat (3) @(posedge CLK);
    #1;
    resetl = 1'b1; stuck = 1'b0;
    dcount = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge CLK); #1;
      if (done) dcount++;
    end
    check("no_done_after_abort", 64'(dcount), 64'd0);
    check("idle_after_abort", {62'd0, busy, proc_resetl}, 64'd1);
    run_one(64'd0, 64'h34, 64'hF, 64'hF, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
